// File: rtl/aes_state_index_sequencer.sv
// Row/column index walker over a ROWS x COLS AES state matrix, column- or row-major order.
// Latency: busy the cycle after start; ROWS*COLS enabled cycles per scan; done pulses the cycle after the last step.
// Backpressure: enable=0 stalls the scan, holding indices and flags; clear aborts the scan to IDLE without a done pulse.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   start, mode           begin a scan (IDLE only); order select, captured on start
//   enable, clear         advance one element; synchronous abort
//   row_idx, col_idx      current element coordinates
//   last_row, last_col    coordinate at its upper bound
//   first, last           first / final element of an active scan
//   step, busy, done      element consumed, scan in progress, scan-complete pulse
module aes_state_index_sequencer #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          enable,
    input  logic          clear,
    output logic [RW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic          last_row,
    output logic          last_col,
    output logic          first,
    output logic          last,
    output logic          step,
    output logic          busy,
    output logic          done
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          mode_q, mode_d;

    // Explicit wrap at the bound so non-power-of-two sizes never reach
    // an out-of-range index.
    logic [RW-1:0] row_inc;
    logic [CW-1:0] col_inc;

    assign last_row = (row_q == ROW_MAX);
    assign last_col = (col_q == COL_MAX);
    assign row_inc  = last_row ? '0 : row_q + 1'b1;
    assign col_inc  = last_col ? '0 : col_q + 1'b1;

    assign row_idx  = row_q;
    assign col_idx  = col_q;
    assign busy     = (state_q == S_RUN);
    assign first    = busy && (row_q == '0) && (col_q == '0);
    assign last     = busy && last_row && last_col;
    assign step     = busy && enable;
    // clear in the DONE cycle suppresses the pulse as well.
    assign done     = (state_q == S_DONE) && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        mode_d  = mode_q;

        if (clear) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    row_d = '0;
                    col_d = '0;
                    if (start) begin
                        state_d = S_RUN;
                        mode_d  = mode;
                    end
                end
                S_RUN: begin
                    if (enable) begin
                        if (!mode_q) begin
                            // column-major: row is the fast coordinate
                            row_d = row_inc;
                            if (last_row) col_d = col_inc;
                        end else begin
                            // row-major: column is the fast coordinate
                            col_d = col_inc;
                            if (last_col) row_d = row_inc;
                        end
                        if (last_row && last_col) begin
                            state_d = S_DONE;
                            row_d   = '0;
                            col_d   = '0;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_state_index_sequencer.sv
// Directed bench for aes_state_index_sequencer: 4x4 scans in both orders, stalls,
// clear and reset aborts, plus 4x8 and 1x4 builds sharing the same clock.
// Inputs are driven 1 ns after the rising edge, outputs sampled 2 ns after it.
module tb_aes_state_index_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic mode = 1'b0, enable = 1'b0, clear = 1'b0;

    always #5 clk = ~clk;

    // 4x4 build
    logic [1:0] row_idx, col_idx;
    logic last_row, last_col, first, last, step, busy, done;
    // 4x8 build
    logic [1:0] b_row;
    logic [2:0] b_col;
    logic b_last_row, b_last_col, b_first, b_last, b_step, b_busy, b_done;
    // 1x4 build
    logic [0:0] c_row;
    logic [1:0] c_col;
    logic c_last_row, c_last_col, c_first, c_last, c_step, c_busy, c_done;

    aes_state_index_sequencer #(.ROWS(4), .COLS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .enable(enable), .clear(clear),
        .row_idx(row_idx), .col_idx(col_idx), .last_row(last_row), .last_col(last_col),
        .first(first), .last(last), .step(step), .busy(busy), .done(done)
    );

    aes_state_index_sequencer #(.ROWS(4), .COLS(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .enable(enable), .clear(clear),
        .row_idx(b_row), .col_idx(b_col), .last_row(b_last_row), .last_col(b_last_col),
        .first(b_first), .last(b_last), .step(b_step), .busy(b_busy), .done(b_done)
    );

    aes_state_index_sequencer #(.ROWS(1), .COLS(4)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode), .enable(enable), .clear(clear),
        .row_idx(c_row), .col_idx(c_col), .last_row(c_last_row), .last_col(c_last_col),
        .first(c_first), .last(c_last), .step(c_step), .busy(c_busy), .done(c_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full 4x4 scan. stall: enable follows 1,0,0,1,0,0,...
    // disturb: toggle mode and pulse start while running (both must be ignored).
    task automatic scan(input logic m, input bit stall, input bit disturb);
        int   k = 0;
        int   cyc = 0;
        int   steps = 0;
        int   er, ec;
        logic en;
        mode   = m;
        start  = 1'b1;
        enable = 1'b0;
        tick;
        start = 1'b0;
        while (k < 16 && cyc < 100) begin
            en = stall ? ((cyc % 3) == 0) : 1'b1;
            enable = en;
            if (disturb) begin
                mode  = m ^ cyc[0];
                start = cyc[1];
            end
            #1;
            er = m ? k / 4 : k % 4;
            ec = m ? k % 4 : k / 4;
            check("scan_row", row_idx, er);
            check("scan_col", col_idx, ec);
            check("scan_first", first, (k == 0));
            check("scan_last", last, (k == 15));
            check("scan_busy", busy, 1);
            check("scan_step", step, en);
            check("scan_done_early", done, 0);
            if (step) steps++;
            if (en) k++;
            tick;
            cyc++;
        end
        start  = 1'b0;
        mode   = m;
        enable = 1'b0;
        #1;
        check("scan_budget", (cyc < 100), 1);
        check("scan_steps", steps, 16);
        check("scan_done", done, 1);
        check("scan_busy_after", busy, 0);
        check("scan_row_after", row_idx, 0);
        check("scan_col_after", col_idx, 0);
        tick;
        check("scan_done_once", done, 0);
        check("scan_idle", busy, 0);
    endtask

    initial begin
        int k;
        int steps;

        // Reset state
        #12;
        check("rst_row", row_idx, 0);
        check("rst_col", col_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last_row", last_row, 0);
        check("rst_c_last_row", c_last_row, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // enable in IDLE is ignored
        enable = 1'b1;
        repeat (3) tick;
        check("idle_en_row", row_idx, 0);
        check("idle_en_col", col_idx, 0);
        check("idle_en_busy", busy, 0);
        check("idle_en_step", step, 0);
        enable = 1'b0;

        scan(1'b0, 1'b0, 1'b0);   // column-major
        scan(1'b1, 1'b0, 1'b1);   // row-major with mode/start disturbance
        scan(1'b0, 1'b1, 1'b0);   // stalled column-major
        scan(1'b1, 1'b1, 1'b0);   // stalled row-major

        // clear at element 7, (3,1) in column-major
        mode = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        enable = 1'b1;
        repeat (7) tick;
        check("clr_pre_row", row_idx, 3);
        check("clr_pre_col", col_idx, 1);
        clear = 1'b1;
        #1;
        check("clr_step_cycle_done", done, 0);
        tick;
        clear = 1'b0;
        #1;
        check("clr_busy", busy, 0);
        check("clr_row", row_idx, 0);
        check("clr_col", col_idx, 0);
        check("clr_done", done, 0);
        tick;
        check("clr_no_done", done, 0);
        check("clr_stay_idle", busy, 0);
        enable = 1'b0;
        scan(1'b0, 1'b0, 1'b0);   // restart from (0,0)

        // start and clear together: clear wins
        start = 1'b1;
        clear = 1'b1;
        tick;
        start = 1'b0;
        clear = 1'b0;
        #1;
        check("start_clear_busy", busy, 0);

        // asynchronous reset at element 5, (1,1)
        start = 1'b1;
        tick;
        start = 1'b0;
        enable = 1'b1;
        repeat (5) tick;
        check("arst_pre_row", row_idx, 1);
        check("arst_pre_col", col_idx, 1);
        rst = 1'b0;
        #1;
        check("arst_row", row_idx, 0);
        check("arst_col", col_idx, 0);
        check("arst_busy", busy, 0);
        start = 1'b1;
        tick;
        tick;
        check("arst_start_ignored", busy, 0);
        check("arst_no_done", done, 0);
        rst = 1'b1;
        start = 1'b0;
        tick;
        check("arst_after_busy", busy, 0);
        check("arst_after_done", done, 0);
        enable = 1'b0;

        // 4x8 build, row-major: 32 steps
        mode = 1'b1;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        enable = 1'b1;
        k = 0;
        steps = 0;
        while (k < 32) begin
            #1;
            check("b_row", b_row, k / 8);
            check("b_col", b_col, k % 8);
            check("b_last_col", b_last_col, ((k % 8) == 7));
            check("b_done_early", b_done, 0);
            if (b_step) steps++;
            k++;
            tick;
        end
        check("b_steps", steps, 32);
        check("b_done", b_done, 1);
        check("b_busy_after", b_busy, 0);
        enable = 1'b0;
        tick;

        // 1x4 build, column-major: 4 steps, row pinned at 0
        mode = 1'b0;
        start_c = 1'b1;
        tick;
        start_c = 1'b0;
        enable = 1'b1;
        k = 0;
        steps = 0;
        while (k < 4) begin
            #1;
            check("c_row", c_row, 0);
            check("c_col", c_col, k);
            check("c_last_row", c_last_row, 1);
            check("c_first", c_first, (k == 0));
            check("c_last", c_last, (k == 3));
            if (c_step) steps++;
            k++;
            tick;
        end
        check("c_steps", steps, 4);
        check("c_done", c_done, 1);
        check("c_last_row_idle", c_last_row, 1);
        enable = 1'b0;
        tick;
        check("c_done_once", c_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
